tpu_control_unit: RTL and testbench

- Receiving end of the TPU instruction stream. Accepts 16-bit instructions (3-bit opcode, 13-bit operand) over a valid/ready handshake.
- Decodes each instruction and sequences the multi-cycle strobes that drive weight memory, the unified buffer and the MMU.
- Owns the address register and the cycle counter. The instruction issuer therefore only fetches and presents instructions; it never times operations itself.
- Sits between the instruction fetch logic and the datapath inside `main`.

---
 rtl/tpu_pkg.sv | 46 ++++
 rtl/tpu_control_unit.sv | 117 +++++++++++
 tb/tb_tpu_control_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU instruction encoding, control-unit state and strobe types.
// Used by the control unit, the instruction fetch logic and the bench.
package tpu_pkg;

    localparam int INSTR_W    = 16;
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 13;
    localparam int OPERAND_W  = 13;

    typedef enum logic [2:0] {
        OP_HALT        = 3'b000,
        OP_LOAD_ADDR   = 3'b001,
        OP_LOAD_WEIGHT = 3'b010,
        OP_LOAD_INPUT  = 3'b011,
        OP_COMPUTE     = 3'b100,
        OP_STORE       = 3'b101
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HALT = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic load_weight;
        logic load_input;
        logic compute;
        logic store;
    } strobe_t;

    // One-hot datapath strobe for a multi-cycle opcode; zero for anything else.
    function automatic strobe_t op_strobe(input opcode_t op);
        strobe_t s;
        s = '0;
        case (op)
            OP_LOAD_WEIGHT: s.load_weight = 1'b1;
            OP_LOAD_INPUT:  s.load_input  = 1'b1;
            OP_COMPUTE:     s.compute     = 1'b1;
            OP_STORE:       s.store       = 1'b1;
            default:        s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tpu_control_unit.sv
// TPU instruction decode and strobe sequencer: accepts one instruction when idle,
// then drives a single datapath strobe for C cycles with an incrementing address.
module tpu_control_unit
    import tpu_pkg::*;
#(
    parameter int LOAD_CYCLES    = 2,
    parameter int COMPUTE_CYCLES = 6,
    parameter int STORE_CYCLES   = 2,
    parameter int ADDR_W         = OPERAND_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               load_weight,
    output logic               load_input,
    output logic               compute_en,
    output logic               store_en,
    output logic               halted,
    output logic               err_illegal
);

    localparam int CNT_W = 8;

    ctrl_state_t          state;
    logic [ADDR_W-1:0]    base_addr;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     last;
    logic [CNT_W-1:0]     cnt_nxt;
    strobe_t              stb;
    opcode_t              opc;
    logic [OPERAND_W-1:0] operand;

    assign opc     = opcode_t'(instruction[OPCODE_MSB:OPCODE_LSB]);
    assign operand = instruction[OPERAND_W-1:0];
    assign cnt_nxt = cnt + CNT_W'(1);

    function automatic logic [CNT_W-1:0] op_cycles(input opcode_t op);
        case (op)
            OP_LOAD_WEIGHT, OP_LOAD_INPUT: return CNT_W'(LOAD_CYCLES);
            OP_COMPUTE:                    return CNT_W'(COMPUTE_CYCLES);
            default:                       return CNT_W'(STORE_CYCLES);
        endcase
    endfunction

    // mem_addr always tracks base_addr + cnt, so it is updated alongside cnt
    // rather than added combinationally on the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            base_addr   <= '0;
            cnt         <= '0;
            last        <= '0;
            stb         <= '0;
            mem_addr    <= '0;
            instr_ready <= 1'b1;
            halted      <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        case (opc)
                            OP_LOAD_ADDR: begin
                                base_addr <= ADDR_W'(operand);
                                mem_addr  <= ADDR_W'(operand);
                            end
                            OP_LOAD_WEIGHT, OP_LOAD_INPUT, OP_COMPUTE, OP_STORE: begin
                                state       <= EXEC;
                                cnt         <= '0;
                                last        <= op_cycles(opc) - CNT_W'(1);
                                stb         <= op_strobe(opc);
                                instr_ready <= 1'b0;
                            end
                            OP_HALT: begin
                                state       <= HALT;
                                instr_ready <= 1'b0;
                                halted      <= 1'b1;
                            end
                            default: err_illegal <= 1'b1;
                        endcase
                    end
                end
                EXEC: begin
                    if (cnt == last) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        stb         <= '0;
                        mem_addr    <= base_addr;
                        instr_ready <= 1'b1;
                    end else begin
                        cnt      <= cnt_nxt;
                        mem_addr <= base_addr + ADDR_W'(cnt_nxt);
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    stb         <= '0;
                    mem_addr    <= base_addr;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

    assign load_weight = stb.load_weight;
    assign load_input  = stb.load_input;
    assign compute_en  = stb.compute;
    assign store_en    = stb.store;

endmodule

// File: tb/tb_tpu_control_unit.sv
// Bench for tpu_control_unit: directed vector table, reset-in-flight sequence,
// and randomized instruction streams checked against a strobe-queue model.
module tb_tpu_control_unit;
    import tpu_pkg::*;

    localparam int LC = 2;
    localparam int CC = 6;
    localparam int SC = 2;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [15:0]   instruction = '0;
    logic [AW-1:0] mem_addr;
    logic          load_weight, load_input, compute_en, store_en, halted, err_illegal;

    int total = 0;
    int bad   = 0;

    tpu_control_unit #(
        .LOAD_CYCLES(LC), .COMPUTE_CYCLES(CC), .STORE_CYCLES(SC), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .mem_addr(mem_addr), .load_weight(load_weight),
        .load_input(load_input), .compute_en(compute_en), .store_en(store_en),
        .halted(halted), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // {ready, addr[12:0], lw, li, ce, se, halted, err}
    logic [19:0] obs;
    assign obs = {instr_ready, mem_addr, load_weight, load_input, compute_en, store_en,
                  halted, err_illegal};

    function automatic logic [19:0] ex(input logic rdy, input logic [12:0] a,
                                       input logic [3:0] s, input logic h, input logic e);
        return {rdy, a, s, h, e};
    endfunction

    function automatic logic [15:0] ins(input logic [2:0] op, input logic [12:0] opd);
        return {op, opd};
    endfunction

    task automatic check(input string name, input logic [19:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got rdy=%0b addr=%h stb=%b hlt=%0b err=%0b, expected rdy=%0b addr=%h stb=%b hlt=%0b err=%0b",
                     name, obs[19], obs[18:6], obs[5:2], obs[1], obs[0],
                     exp[19], exp[18:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    typedef struct {
        logic        vld;
        logic [15:0] ins;
        logic [19:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic v, input logic [15:0] i, input logic [19:0] e);
        vec_t r;
        r.vld = v;
        r.ins = i;
        r.exp = e;
        tbl.push_back(r);
    endtask

    // Reference model: every accepted multi-cycle op appends one entry per strobe
    // cycle; each clock edge consumes one entry.
    typedef struct packed {
        logic [3:0]  stb;
        logic [12:0] addr;
    } beat_t;
    beat_t       mq[$];
    logic [12:0] m_base;
    logic        m_halt, m_err;

    function automatic logic [19:0] m_expect();
        if (mq.size() != 0) return {1'b0, mq[0].addr, mq[0].stb, 1'b0, m_err};
        return {~m_halt, m_base, 4'b0000, m_halt, m_err};
    endfunction

    task automatic m_push(input logic [3:0] s, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.stb  = s;
            b.addr = m_base + 13'(i);
            mq.push_back(b);
        end
    endtask

    task automatic model_edge(input logic v, input logic [15:0] in);
        logic rdy;
        rdy = (mq.size() == 0) && !m_halt;
        if (mq.size() != 0) void'(mq.pop_front());
        if (v && rdy) begin
            case (in[15:13])
                3'b000: m_halt = 1'b1;
                3'b001: m_base = in[12:0];
                3'b010: m_push(4'b1000, LC);
                3'b011: m_push(4'b0100, LC);
                3'b100: m_push(4'b0010, CC);
                3'b101: m_push(4'b0001, SC);
                default: m_err = 1'b1;
            endcase
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        @(negedge clk);
        reset = 1'b0;
        mq.delete();
        m_base = '0;
        m_halt = 1'b0;
        m_err  = 1'b0;
    endtask

    initial begin
        // Directed table: each row's inputs are sampled at one edge, and the
        // expected outputs are those visible during the following cycle.
        add(1, ins(OP_LOAD_ADDR, 13'h000F),   ex(1, 13'h000F, 4'b0000, 0, 0));
        add(1, ins(OP_LOAD_WEIGHT, 13'h0000), ex(0, 13'h000F, 4'b1000, 0, 0));
        add(0, 16'h0000,                      ex(0, 13'h0010, 4'b1000, 0, 0));
        add(0, 16'h0000,                      ex(1, 13'h000F, 4'b0000, 0, 0));
        add(1, ins(OP_LOAD_ADDR, 13'h1FFF),   ex(1, 13'h1FFF, 4'b0000, 0, 0));
        add(1, ins(OP_STORE, 13'h0000),       ex(0, 13'h1FFF, 4'b0001, 0, 0));
        add(0, 16'h0000,                      ex(0, 13'h0000, 4'b0001, 0, 0));
        add(0, 16'h0000,                      ex(1, 13'h1FFF, 4'b0000, 0, 0));
        add(1, ins(3'b111, 13'h0000),         ex(1, 13'h1FFF, 4'b0000, 0, 1));
        add(1, ins(OP_LOAD_ADDR, 13'h0003),   ex(1, 13'h0003, 4'b0000, 0, 1));
        add(1, ins(OP_COMPUTE, 13'h0000),     ex(0, 13'h0003, 4'b0010, 0, 1));
        for (int k = 1; k <= 5; k++)
            add(1, ins(OP_STORE, 13'h0000),   ex(0, 13'(3 + k), 4'b0010, 0, 1));
        add(1, ins(OP_STORE, 13'h0000),       ex(1, 13'h0003, 4'b0000, 0, 1));
        add(1, ins(OP_STORE, 13'h0000),       ex(0, 13'h0003, 4'b0001, 0, 1));
        add(0, 16'h0000,                      ex(0, 13'h0004, 4'b0001, 0, 1));
        add(0, 16'h0000,                      ex(1, 13'h0003, 4'b0000, 0, 1));
        add(1, ins(OP_LOAD_ADDR, 13'h001E),   ex(1, 13'h001E, 4'b0000, 0, 1));
        add(1, ins(OP_LOAD_INPUT, 13'h0000),  ex(0, 13'h001E, 4'b0100, 0, 1));
        add(1, ins(OP_COMPUTE, 13'h0000),     ex(0, 13'h001F, 4'b0100, 0, 1));
        add(1, ins(OP_COMPUTE, 13'h0000),     ex(1, 13'h001E, 4'b0000, 0, 1));
        add(1, ins(OP_COMPUTE, 13'h0000),     ex(0, 13'h001E, 4'b0010, 0, 1));
        for (int k = 1; k <= 5; k++)
            add(1, ins(OP_LOAD_ADDR, 13'h0007), ex(0, 13'(30 + k), 4'b0010, 0, 1));
        add(1, ins(OP_LOAD_ADDR, 13'h0007),   ex(1, 13'h001E, 4'b0000, 0, 1));
        add(1, ins(OP_LOAD_ADDR, 13'h0007),   ex(1, 13'h0007, 4'b0000, 0, 1));
        add(1, ins(OP_STORE, 13'h0000),       ex(0, 13'h0007, 4'b0001, 0, 1));
        add(1, ins(OP_HALT, 13'h0000),        ex(0, 13'h0008, 4'b0001, 0, 1));
        add(1, ins(OP_HALT, 13'h0000),        ex(1, 13'h0007, 4'b0000, 0, 1));
        add(1, ins(OP_HALT, 13'h0000),        ex(0, 13'h0007, 4'b0000, 1, 1));
        add(0, 16'h0000,                      ex(0, 13'h0007, 4'b0000, 1, 1));
        add(1, ins(OP_LOAD_ADDR, 13'h0000),   ex(0, 13'h0007, 4'b0000, 1, 1));
        add(1, ins(OP_COMPUTE, 13'h0000),     ex(0, 13'h0007, 4'b0000, 1, 1));

        do_reset();
        check("reset_state", ex(1, 13'h0000, 4'b0000, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            instr_valid = tbl[i].vld;
            instruction = tbl[i].ins;
            @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Reset landing in the third compute cycle.
        do_reset();
        instr_valid = 1'b1;
        instruction = ins(OP_LOAD_ADDR, 13'h0010);
        @(negedge clk);
        instruction = ins(OP_COMPUTE, 13'h0000);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_compute", ex(0, 13'h0012, 4'b0010, 0, 0));
        reset = 1'b1;
        #1;
        check("reset_cut", ex(1, 13'h0000, 4'b0000, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        check("after_release", ex(1, 13'h0000, 4'b0000, 0, 0));
        @(negedge clk);
        check("no_resume", ex(1, 13'h0000, 4'b0000, 0, 0));
        instr_valid = 1'b1;
        instruction = ins(OP_LOAD_ADDR, 13'h0005);
        @(negedge clk);
        instr_valid = 1'b0;
        check("load_addr_after_reset", ex(1, 13'h0005, 4'b0000, 0, 0));

        // Randomized instruction streams against the queue model.
        for (int ep = 0; ep < 10; ep++) begin
            do_reset();
            for (int c = 0; c < 400; c++) begin
                logic        v;
                logic [2:0]  op;
                logic [12:0] opd;
                int          r;
                check($sformatf("rand_ep%0d_c%0d", ep, c), m_expect());
                r = $urandom_range(0, 99);
                if (r < 2)       op = 3'b000;
                else if (r < 25) op = 3'b001;
                else if (r < 40) op = 3'b010;
                else if (r < 55) op = 3'b011;
                else if (r < 70) op = 3'b100;
                else if (r < 85) op = 3'b101;
                else             op = 3'(6 + $urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) opd = 13'h1FFF - 13'($urandom_range(0, 4));
                else                           opd = 13'($urandom);
                v = ($urandom_range(0, 3) != 0);
                instr_valid = v;
                instruction = {op, opd};
                model_edge(v, {op, opd});
                @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
